// File: rtl/riscv_multi_cycle_core.sv
// rtl/riscv_multi_cycle_core.sv - multi-cycle RV32I-subset core with one shared memory port
// Purpose: FETCH/DECODE/EXEC/MEM/WB/HALT sequenced core; memory accesses use a
//          req/ready handshake so any number of wait states is tolerated.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_req/mem_we        request valid / store select (0 = fetch or load)
//   mem_addr/mem_wdata    word-aligned byte address / store data (0 when idle)
//   mem_ready/mem_rdata   access completes this cycle / fetch or load data
//   pc_out/instr_out      PC of instruction in flight / latched instruction
//   retire                one-cycle pulse as an instruction completes
//   halted                sticky fault indication (illegal or misaligned)
module riscv_multi_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32,
    parameter int          XLEN     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        retire,
    output logic        halted
);
    localparam int RW = $clog2(NUM_REGS);

    generate
        if (XLEN != 32) begin : g_bad_xlen
            $error("riscv_multi_cycle_core: XLEN must be 32");
        end
        if (NUM_REGS != 32 && NUM_REGS != 16) begin : g_bad_regs
            $error("riscv_multi_cycle_core: NUM_REGS must be 16 or 32");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      r_state, w_next_state;
    // Cleared by reset so the first request only rises on the first edge after release.
    logic        r_armed;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_result, r_addr, r_next_pc;
    logic [31:0] r_regs [NUM_REGS];

    logic [6:0]  w_opcode, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic        w_is_lui, w_is_jal, w_is_jalr, w_is_br, w_is_lw, w_is_sw, w_is_opimm, w_is_op;
    logic        w_legal, w_use_rd, w_use_rs1, w_use_rs2, w_illegal;
    logic [31:0] w_imm, w_rs1_val, w_rs2_val, w_op2, w_alu, w_pc4, w_ls_addr, w_jtarget;
    logic        w_taken;

    assign w_opcode   = r_ir[6:0];
    assign w_rd       = r_ir[11:7];
    assign w_f3       = r_ir[14:12];
    assign w_rs1      = r_ir[19:15];
    assign w_rs2      = r_ir[24:20];
    assign w_f7       = r_ir[31:25];
    assign w_is_lui   = (w_opcode == 7'b0110111);
    assign w_is_jal   = (w_opcode == 7'b1101111);
    assign w_is_jalr  = (w_opcode == 7'b1100111);
    assign w_is_br    = (w_opcode == 7'b1100011);
    assign w_is_lw    = (w_opcode == 7'b0000011);
    assign w_is_sw    = (w_opcode == 7'b0100011);
    assign w_is_opimm = (w_opcode == 7'b0010011);
    assign w_is_op    = (w_opcode == 7'b0110011);

    always_comb begin
        w_legal   = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        if (w_is_lui || w_is_jal) begin
            w_legal  = 1'b1;
            w_use_rd = 1'b1;
        end else if (w_is_jalr || w_is_lw) begin
            w_legal   = w_is_jalr ? (w_f3 == 3'b000) : (w_f3 == 3'b010);
            w_use_rd  = 1'b1;
            w_use_rs1 = 1'b1;
        end else if (w_is_br || w_is_sw) begin
            w_legal   = w_is_br ? (w_f3[2:1] == 2'b00) : (w_f3 == 3'b010);
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
        end else if (w_is_opimm) begin
            // No immediate shifts and no sltiu.
            w_legal   = (w_f3 != 3'b001) && (w_f3 != 3'b011) && (w_f3 != 3'b101);
            w_use_rd  = 1'b1;
            w_use_rs1 = 1'b1;
        end else if (w_is_op) begin
            w_legal   = ((w_f7 == 7'b0000000) && (w_f3 != 3'b011)) ||
                        ((w_f7 == 7'b0100000) && (w_f3 == 3'b000));
            w_use_rd  = 1'b1;
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
        end
        w_illegal = !w_legal ||
                    (w_use_rd  && ({27'd0, w_rd}  >= NUM_REGS)) ||
                    (w_use_rs1 && ({27'd0, w_rs1} >= NUM_REGS)) ||
                    (w_use_rs2 && ({27'd0, w_rs2} >= NUM_REGS));
    end

    always_comb begin
        w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        if (w_is_sw)
            w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        else if (w_is_br)
            w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
        else if (w_is_jal)
            w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
        else if (w_is_lui)
            w_imm = {r_ir[31:12], 12'd0};
    end

    // Out-of-range indices never reach EXEC (DECODE halts), so they may read as 0 here.
    assign w_rs1_val = (w_rs1 == 5'd0 || {27'd0, w_rs1} >= NUM_REGS) ? 32'd0 : r_regs[w_rs1[RW-1:0]];
    assign w_rs2_val = (w_rs2 == 5'd0 || {27'd0, w_rs2} >= NUM_REGS) ? 32'd0 : r_regs[w_rs2[RW-1:0]];

    assign w_op2 = w_is_op ? r_b : r_imm;
    always_comb begin
        case (w_f3)
            3'b000:  w_alu = (w_is_op && w_f7[5]) ? (r_a - w_op2) : (r_a + w_op2);
            3'b001:  w_alu = r_a << w_op2[4:0];
            3'b010:  w_alu = {31'd0, $signed(r_a) < $signed(w_op2)};
            3'b100:  w_alu = r_a ^ w_op2;
            3'b101:  w_alu = r_a >> w_op2[4:0];
            3'b110:  w_alu = r_a | w_op2;
            default: w_alu = r_a & w_op2;
        endcase
    end

    assign w_pc4     = r_pc + 32'd4;
    assign w_taken   = w_f3[0] ? (r_a != r_b) : (r_a == r_b);
    assign w_ls_addr = r_a + r_imm;
    assign w_jtarget = w_is_jal ? (r_pc + r_imm) : ((r_a + r_imm) & ~32'd1);

    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        retire       = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req  = r_armed;
                mem_addr = r_armed ? r_pc : 32'd0;
                if (r_armed && mem_ready) w_next_state = S_DECODE;
            end
            S_DECODE: w_next_state = w_illegal ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (w_is_br) begin
                    retire       = 1'b1;
                    w_next_state = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next_state = (w_ls_addr[1:0] != 2'b00) ? S_HALT : S_MEM;
                end else if (w_is_jal || w_is_jalr) begin
                    w_next_state = (w_jtarget[1:0] != 2'b00) ? S_HALT : S_WB;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = w_is_sw;
                mem_addr  = r_addr;
                mem_wdata = w_is_sw ? r_b : 32'd0;
                if (mem_ready) begin
                    retire       = w_is_sw;
                    w_next_state = w_is_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                retire       = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_HALT;
        endcase
    end

    assign halted    = (r_state == S_HALT);
    assign pc_out    = r_pc;
    assign instr_out = r_ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_armed   <= 1'b0;
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_imm     <= 32'd0;
            r_result  <= 32'd0;
            r_addr    <= 32'd0;
            r_next_pc <= 32'd0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_armed <= 1'b1;
            case (r_state)
                S_FETCH: if (r_armed && mem_ready) r_ir <= mem_rdata;
                S_DECODE: begin
                    r_a   <= w_rs1_val;
                    r_b   <= w_rs2_val;
                    r_imm <= w_imm;
                end
                S_EXEC: begin
                    if (w_is_br) r_pc <= w_taken ? (r_pc + r_imm) : w_pc4;
                    r_addr    <= w_ls_addr;
                    r_result  <= w_is_lui ? r_imm : ((w_is_jal || w_is_jalr) ? w_pc4 : w_alu);
                    r_next_pc <= (w_is_jal || w_is_jalr) ? w_jtarget : w_pc4;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_is_sw) r_pc <= w_pc4;
                        else         r_result <= mem_rdata;
                    end
                end
                S_WB: begin
                    if (w_rd != 5'd0) r_regs[w_rd[RW-1:0]] <= r_result;
                    r_pc <= r_next_pc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_multi_cycle_core.sv
// tb/tb_riscv_multi_cycle_core.sv - directed and randomized bench for riscv_multi_cycle_core
module tb_riscv_multi_cycle_core;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instr_out;

    riscv_multi_cycle_core #(.RESET_PC(32'h0), .NUM_REGS(32), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .pc_out(pc_out), .instr_out(instr_out),
        .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLT, K_SLL, K_SRL,
                      K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI, K_LUI, K_SW, K_LW,
                      K_BEQ, K_BNE, K_JAL, K_JALR} kind_t;
    typedef struct { kind_t k; int rd; int rs1; int rs2; int imm; } op_t;

    logic [31:0] mem [256];
    logic [31:0] mm  [256];
    assign mem_rdata = mem[mem_addr[9:2]];

    int n_checks = 0, n_pass = 0;
    int cyc = 0, t_first = -1;
    int ready_mode = 0, mem_stall = 0;
    logic [31:0] q_ret_pc[$], q_fetch[$], q_st_addr[$], q_st_data[$];
    int          q_ret_cyc[$];
    logic [31:0] exp_ret[$], exp_st_addr[$], exp_st_data[$];
    logic [31:0] exp_halt_pc;
    op_t         prog[$];
    logic        pend = 1'b0, p_we;
    logic [31:0] p_addr, p_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    function automatic op_t mk(kind_t k, int rd, int rs1, int rs2, int imm);
        op_t o;
        o.k = k; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm;
        return o;
    endfunction

    function automatic logic [31:0] enc(op_t o);
        logic [31:0] im;
        logic [4:0]  rd, r1, r2;
        im = o.imm; rd = o.rd[4:0]; r1 = o.rs1[4:0]; r2 = o.rs2[4:0];
        case (o.k)
            K_ADD:  return {7'h00, r2, r1, 3'b000, rd, 7'h33};
            K_SUB:  return {7'h20, r2, r1, 3'b000, rd, 7'h33};
            K_SLL:  return {7'h00, r2, r1, 3'b001, rd, 7'h33};
            K_SLT:  return {7'h00, r2, r1, 3'b010, rd, 7'h33};
            K_XOR:  return {7'h00, r2, r1, 3'b100, rd, 7'h33};
            K_SRL:  return {7'h00, r2, r1, 3'b101, rd, 7'h33};
            K_OR:   return {7'h00, r2, r1, 3'b110, rd, 7'h33};
            K_AND:  return {7'h00, r2, r1, 3'b111, rd, 7'h33};
            K_ADDI: return {im[11:0], r1, 3'b000, rd, 7'h13};
            K_SLTI: return {im[11:0], r1, 3'b010, rd, 7'h13};
            K_XORI: return {im[11:0], r1, 3'b100, rd, 7'h13};
            K_ORI:  return {im[11:0], r1, 3'b110, rd, 7'h13};
            K_ANDI: return {im[11:0], r1, 3'b111, rd, 7'h13};
            K_LUI:  return {im[19:0], rd, 7'h37};
            K_SW:   return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
            K_LW:   return {im[11:0], r1, 3'b010, rd, 7'h03};
            K_BEQ:  return {im[12], im[10:5], r2, r1, 3'b000, im[4:1], im[11], 7'h63};
            K_BNE:  return {im[12], im[10:5], r2, r1, 3'b001, im[4:1], im[11], 7'h63};
            K_JAL:  return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
            default: return {im[11:0], r1, 3'b000, rd, 7'h67};
        endcase
    endfunction

    task automatic put(input int addr, input op_t o);
        mem[addr / 4] = enc(o);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        q_ret_pc.delete(); q_ret_cyc.delete(); q_fetch.delete();
        q_st_addr.delete(); q_st_data.delete();
        t_first = -1;
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !halted; i++) @(negedge clk);
        chk(tag, halted, 1'b1);
    endtask

    // Instruction-level reference: walks the op list, one entry per word from address 0.
    task automatic run_model();
        logic [31:0] x [32];
        logic [31:0] a, b, r, npc, pc;
        for (int i = 0; i < 32; i++) x[i] = 32'd0;
        exp_ret.delete(); exp_st_addr.delete(); exp_st_data.delete();
        pc = 32'd0;
        while (pc / 4 < prog.size()) begin
            op_t o;
            o = prog[pc / 4];
            a = x[o.rs1]; b = x[o.rs2]; npc = pc + 4; r = 32'd0;
            exp_ret.push_back(pc);
            case (o.k)
                K_ADD:  r = a + b;
                K_SUB:  r = a - b;
                K_AND:  r = a & b;
                K_OR:   r = a | b;
                K_XOR:  r = a ^ b;
                K_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                K_SLL:  r = a << (b % 32);
                K_SRL:  r = a >> (b % 32);
                K_ADDI: r = a + o.imm;
                K_ANDI: r = a & o.imm;
                K_ORI:  r = a | o.imm;
                K_XORI: r = a ^ o.imm;
                K_SLTI: r = ($signed(a) < o.imm) ? 32'd1 : 32'd0;
                K_LUI:  r = o.imm * 4096;
                K_LW:   r = mm[o.imm / 4];
                K_SW: begin
                    exp_st_addr.push_back(o.imm);
                    exp_st_data.push_back(b);
                    mm[o.imm / 4] = b;
                end
                K_BEQ:  if (a == b) npc = pc + o.imm;
                K_BNE:  if (a != b) npc = pc + o.imm;
                default: ;
            endcase
            if (o.k != K_SW && o.k != K_BEQ && o.k != K_BNE && o.rd != 0) x[o.rd] = r;
            pc = npc;
        end
        exp_halt_pc = pc;
    endtask

    function automatic op_t rnd_op();
        int sel, rd, rs1, rs2;
        sel = $urandom_range(0, 10);
        rd  = $urandom_range(1, 7);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        if (sel <= 4)      return mk(kind_t'($urandom_range(0, 7)), rd, rs1, rs2, 0);
        else if (sel <= 6) return mk(kind_t'(8 + $urandom_range(0, 4)), rd, rs1, 0,
                                     int'($urandom_range(0, 4095)) - 2048);
        else if (sel == 7) return mk(K_LUI, rd, 0, 0, int'($urandom_range(0, 20'hFFFFF)));
        else if (sel == 8) return mk(K_SW, 0, 0, rs2, 32'h200 + 4 * int'($urandom_range(0, 31)));
        else if (sel == 9) return mk(($urandom_range(0, 1) != 0) ? K_BEQ : K_BNE, 0, rs1, rs2, 8);
        else               return mk(K_LW, rd, 0, 0, 32'h200 + 4 * int'($urandom_range(0, 31)));
    endfunction

    // Memory ready driver: decided just after each rising edge.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) mem_ready = 1'b0;
            else if (mem_req && mem_addr != pc_out && mem_stall > 0) begin
                mem_ready = 1'b0;
                mem_stall--;
            end else if (ready_mode == 1) mem_ready = ($urandom_range(0, 2) != 0);
            else mem_ready = 1'b1;
        end
    end

    // Monitor and memory model, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) pend = 1'b0;
        else begin
            if (pend) begin
                chk("hold_req",   mem_req,   1'b1);
                chk("hold_addr",  mem_addr,  p_addr);
                chk("hold_we",    mem_we,    p_we);
                chk("hold_wdata", mem_wdata, p_wdata);
            end
            if (t_first < 0 && mem_req) t_first = cyc;
            if (retire) begin
                q_ret_pc.push_back(pc_out);
                q_ret_cyc.push_back(cyc);
            end
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    q_st_addr.push_back(mem_addr);
                    q_st_data.push_back(mem_wdata);
                end else if (mem_addr == pc_out) q_fetch.push_back(mem_addr);
            end
            pend = mem_req && !mem_ready;
            p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_out, 32'h0);       chk("rst_ir", instr_out, 32'h0);
        chk("rst_req", mem_req, 1'b0);      chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);   chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_retire", retire, 1'b0);    chk("rst_halted", halted, 1'b0);

        // addi/addi/add then store of the sum; every instruction takes 4 cycles
        clear_mem();
        put(32'h00, mk(K_ADDI, 1, 0, 0, 5));
        put(32'h04, mk(K_ADDI, 2, 0, 0, 7));
        put(32'h08, mk(K_ADD, 3, 1, 2, 0));
        put(32'h0C, mk(K_SW, 0, 0, 3, 32'h100));
        do_reset();
        wait_halt("t1_halt", 200);
        chk("t1_nret", q_ret_cyc.size(), 4);
        chk("t1_lat0", q_ret_cyc[0] - t_first + 1, 4);
        chk("t1_lat1", q_ret_cyc[1] - q_ret_cyc[0], 4);
        chk("t1_lat2", q_ret_cyc[2] - q_ret_cyc[1], 4);
        chk("t1_sw_lat", q_ret_cyc[3] - q_ret_cyc[2], 4);
        chk("t1_st_addr", q_st_addr[0], 32'h100);
        chk("t1_st_data", q_st_data[0], 32'd12);
        chk("t1_halt_pc", pc_out, 32'h10);

        // lw with three wait cycles during MEM
        clear_mem();
        mem[32'h100 / 4] = 32'hCAFE_1234;
        put(32'h00, mk(K_LW, 5, 0, 0, 32'h100));
        put(32'h04, mk(K_SW, 0, 0, 5, 32'h104));
        mem_stall = 3;
        do_reset();
        wait_halt("t2_halt", 200);
        chk("t2_lw_lat", q_ret_cyc[0] - t_first + 1, 8);
        chk("t2_st_addr", q_st_addr[0], 32'h104);
        chk("t2_st_data", q_st_data[0], 32'hCAFE_1234);

        // beq taken, bne not taken, bne taken
        clear_mem();
        put(32'h00, mk(K_JAL, 0, 0, 0, 16));
        put(32'h10, mk(K_BEQ, 0, 0, 0, 8));
        put(32'h18, mk(K_BNE, 0, 0, 0, 8));
        put(32'h1C, mk(K_ADDI, 1, 0, 0, 1));
        put(32'h20, mk(K_BNE, 0, 1, 0, 8));
        do_reset();
        wait_halt("t3_halt", 200);
        chk("t3_fetch_beq", q_fetch[2], 32'h18);
        chk("t3_fetch_bne_nt", q_fetch[3], 32'h1C);
        chk("t3_fetch_bne_t", q_fetch[5], 32'h28);
        chk("t3_beq_lat", q_ret_cyc[1] - q_ret_cyc[0], 3);
        chk("t3_halt_pc", pc_out, 32'h28);

        // jal link value and jalr with bit 0 cleared
        clear_mem();
        put(32'h00, mk(K_JAL, 0, 0, 0, 32));
        put(32'h20, mk(K_JAL, 1, 0, 0, 16));
        put(32'h30, mk(K_JALR, 0, 1, 0, 1));
        put(32'h24, mk(K_SW, 0, 0, 1, 32'h100));
        do_reset();
        wait_halt("t4_halt", 200);
        chk("t4_fetch_jal", q_fetch[2], 32'h30);
        chk("t4_fetch_jalr", q_fetch[3], 32'h24);
        chk("t4_link", q_st_data[0], 32'h24);
        chk("t4_jal_lat", q_ret_cyc[1] - q_ret_cyc[0], 4);

        // misaligned store halts without issuing the store
        clear_mem();
        put(32'h00, mk(K_ADDI, 1, 0, 0, 2));
        put(32'h04, mk(K_SW, 0, 1, 1, 32'h100));
        do_reset();
        wait_halt("t5_halt", 200);
        repeat (4) @(negedge clk);
        chk("t5_halted", halted, 1'b1);
        chk("t5_no_store", q_st_addr.size(), 0);
        chk("t5_req", mem_req, 1'b0);
        chk("t5_pc", pc_out, 32'h4);
        chk("t5_nret", q_ret_pc.size(), 1);

        // reset during a stalled fetch
        ready_mode = 2;
        do_reset();
        repeat (3) @(negedge clk);
        chk("t6_stuck_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req_drop", mem_req, 1'b0);
        chk("t6_rst_addr", mem_addr, 32'h0);
        chk("t6_rst_halted", halted, 1'b0);
        clear_mem();
        put(32'h00, mk(K_ADDI, 1, 0, 0, 9));
        put(32'h04, mk(K_SW, 0, 0, 1, 32'h100));
        ready_mode = 0;
        do_reset();
        wait_halt("t6_halt", 200);
        chk("t6_first_fetch", q_fetch[0], 32'h0);
        chk("t6_st_data", q_st_data[0], 32'd9);

        // random programs with random wait states
        ready_mode = 1;
        for (int p = 0; p < 3; p++) begin
            clear_mem();
            prog.delete();
            for (int i = 0; i < 40; i++) prog.push_back(rnd_op());
            for (int i = 1; i < 8; i++) prog.push_back(mk(K_SW, 0, 0, i, 32'h300 + 4 * i));
            for (int i = 0; i < prog.size(); i++) mem[i] = enc(prog[i]);
            for (int i = 32'h200 / 4; i < 32'h280 / 4; i++) mem[i] = $urandom;
            mm = mem;
            run_model();
            do_reset();
            wait_halt($sformatf("rnd%0d_halt", p), 5000);
            chk($sformatf("rnd%0d_nret", p), q_ret_pc.size(), exp_ret.size());
            for (int i = 0; i < exp_ret.size() && i < q_ret_pc.size(); i++)
                chk($sformatf("rnd%0d_ret%0d", p, i), q_ret_pc[i], exp_ret[i]);
            chk($sformatf("rnd%0d_nst", p), q_st_addr.size(), exp_st_addr.size());
            for (int i = 0; i < exp_st_addr.size() && i < q_st_addr.size(); i++) begin
                chk($sformatf("rnd%0d_sta%0d", p, i), q_st_addr[i], exp_st_addr[i]);
                chk($sformatf("rnd%0d_std%0d", p, i), q_st_data[i], exp_st_data[i]);
            end
            chk($sformatf("rnd%0d_halt_pc", p), pc_out, exp_halt_pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
